alu_exec_stage: RTL and testbench

//  Issue/writeback stage wrapped around the 16-bit ALU. Accepts one instruction per handshake,

---
 rtl/alu_exec_stage.sv | 151 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Issue/writeback stage around an external 16-bit ALU: register file, operand
// staging, result capture, writeback and flags. Fixed 4-cycle sequence per
// instruction (IDLE -> READ -> EXEC -> WB).
module alu_exec_stage #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  input  logic [15:0]                 instr,
  output logic                        instr_ready,
  input  logic                        ld_en,
  input  logic [$clog2(NREG)-1:0]     ld_addr,
  input  logic [DW-1:0]               ld_data,
  output logic [DW-1:0]               alu_a,
  output logic [DW-1:0]               alu_b,
  output logic [2:0]                  alu_sel,
  output logic [3:0]                  alu_shamt,
  input  logic [DW-1:0]               alu_out,
  input  logic                        alu_carry,
  output logic                        wb_valid,
  output logic [$clog2(NREG)-1:0]     wb_addr,
  output logic [DW-1:0]               wb_data,
  output logic                        carry_flag,
  output logic                        zero_flag,
  output logic                        busy
);

  localparam int unsigned RA_W = $clog2(NREG);

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [3:0] shamt;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  instr_t          ir;
  logic            cy;
  logic [DW-1:0]   rf [NREG];

  logic            accept;
  logic [RA_W-1:0] rd_idx;
  logic [RA_W-1:0] rs_idx;
  logic [RA_W-1:0] rt_idx;

  assign accept = (state == S_IDLE) && instr_valid;
  assign rd_idx = RA_W'(ir.rd);
  assign rs_idx = RA_W'(ir.rs);
  assign rt_idx = RA_W'(ir.rt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed walk through the four phases, no stalls
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake/status decode from the state register
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    if (state == S_IDLE) begin
      instr_ready = 1'b1;
      busy        = 1'b0;
    end
  end

  // Instruction register, loaded on the accept handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ir <= '0;
    else if (accept) ir <= instr_t'(instr);
  end

  // ALU operand staging; held stable from READ until the next READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      alu_shamt <= '0;
    end else if (state == S_READ) begin
      alu_a     <= rf[rs_idx];
      alu_b     <= rf[rt_idx];
      alu_sel   <= ir.op;
      alu_shamt <= ir.shamt;
    end
  end

  // Result capture in EXEC; wb_data doubles as the result register seen in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      cy       <= 1'b0;
    end else begin
      wb_valid <= (state == S_EXEC);
      if (state == S_EXEC) begin
        wb_addr <= rd_idx;
        wb_data <= alu_out;
        cy      <= alu_carry;
      end
    end
  end

  // Flag commit at the end of WB; carry is only touched by ADD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state == S_WB) begin
      zero_flag <= (wb_data == '0);
      if (ir.op == 3'b000) carry_flag <= cy;
    end
  end

  // Register file: preload in IDLE, writeback in WB; R0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if ((state == S_IDLE) && ld_en && (ld_addr != '0)) begin
      rf[ld_addr] <= ld_data;
    end else if ((state == S_WB) && (rd_idx != '0)) begin
      rf[rd_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage with a behavioural ALU
// and an architectural model (register array + flags) of the stage.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_shamt;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        carry_flag;
  logic        zero_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf_m [8];
  logic        carry_m;
  logic        zero_m;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_carry(alu_carry), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .carry_flag(carry_flag), .zero_flag(zero_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: {carry of a+b, result}
  function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh);
    logic [16:0] sum;
    logic [15:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd0:    r = sum[15:0];
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a >> sh;
      default: r = a << sh;
    endcase
    return {sum[16], r};
  endfunction

  assign {alu_carry, alu_out} = alu_ref(alu_sel, alu_a, alu_b, alu_shamt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    carry_m = 1'b0;
    zero_m  = 1'b0;
  endtask

  // Issue one instruction (optionally with a same-cycle preload) and check it end to end
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [3:0] sh, input logic ld,
                           input logic [2:0] la, input logic [15:0] ldd);
    int          n;
    logic [15:0] a, b;
    logic [16:0] cr;
    @(negedge clk);
    check("ready_in_idle", instr_ready, 1);
    instr       = {op, rd, rs, rt, sh};
    instr_valid = 1'b1;
    ld_en       = ld;
    ld_addr     = la;
    ld_data     = ldd;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    ld_en       = 1'b0;
    if (ld && la != 3'd0) rf_m[la] = ldd;
    a  = rf_m[rs];
    b  = rf_m[rt];
    cr = alu_ref(op, a, b, sh);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_valid && n < 8);
    check("wb_latency", n, 3);
    check("wb_valid", wb_valid, 1);
    check("wb_addr", wb_addr, rd);
    check("wb_data", wb_data, cr[15:0]);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_sel", alu_sel, op);
    check("alu_shamt", alu_shamt, sh);
    check("busy_in_wb", busy, 1);
    if (rd != 3'd0) rf_m[rd] = cr[15:0];
    zero_m = (cr[15:0] == 16'h0);
    if (op == 3'd0) carry_m = cr[16];
    @(negedge clk);
    check("wb_pulse_end", wb_valid, 0);
    check("carry_flag", carry_flag, carry_m);
    check("zero_flag", zero_flag, zero_m);
    check("busy_after", busy, 0);
  endtask

  task automatic preload(input logic [2:0] la, input logic [15:0] ldd);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = la;
    ld_data = ldd;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    if (la != 3'd0) rf_m[la] = ldd;
  endtask

  // Read a register through the datapath: OR R0, rX, R0
  task automatic read_reg(input logic [2:0] r);
    run_instr(3'd3, 3'd0, r, 3'd0, 4'd0, 1'b0, 3'd0, 16'h0);
  endtask

  initial begin
    int          n;
    logic [16:0] cr;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("init_ready", instr_ready, 1);
    check("init_carry", carry_flag, 0);
    check("init_zero", zero_flag, 0);
    check("init_alu_a", alu_a, 0);
    check("init_wb_data", wb_data, 0);

    // Reset in the middle of EXEC abandons the instruction
    preload(3'd2, 16'h0005);
    preload(3'd3, 16'h0007);
    @(negedge clk);
    instr = {3'd0, 3'd1, 3'd2, 3'd3, 4'd0};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_wb", wb_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_busy_after", busy, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_alu_b", alu_b, 0);
    read_reg(3'd1);
    read_reg(3'd2);
    read_reg(3'd3);

    // ADD with carry-out and zero result
    preload(3'd2, 16'hFFFF);
    preload(3'd3, 16'h0001);
    run_instr(3'd0, 3'd1, 3'd2, 3'd3, 4'd0, 1'b0, 3'd0, 16'h0);
    read_reg(3'd1);
    // SUB leaves carry_flag alone
    run_instr(3'd1, 3'd4, 3'd2, 3'd3, 4'd0, 1'b0, 3'd0, 16'h0);
    read_reg(3'd4);
    // LSL by the maximum shift
    run_instr(3'd7, 3'd5, 3'd3, 3'd0, 4'hF, 1'b0, 3'd0, 16'h0);
    read_reg(3'd5);
    // Write to R0 is dropped but still pulses wb_valid
    run_instr(3'd4, 3'd0, 3'd2, 3'd3, 4'd0, 1'b0, 3'd0, 16'h0);
    read_reg(3'd0);
    // Preload of R0 is dropped; simultaneous preload + instruction reads the new value
    preload(3'd0, 16'hABCD);
    read_reg(3'd0);
    run_instr(3'd0, 3'd6, 3'd6, 3'd6, 4'd0, 1'b1, 3'd6, 16'h8001);
    read_reg(3'd6);

    // Back-to-back with instr_valid held high: ADD R7,R7,R3; ld_en while busy ignored
    preload(3'd7, 16'hFFFE);
    preload(3'd3, 16'h0001);
    @(negedge clk);
    instr = {3'd0, 3'd7, 3'd7, 3'd3, 4'd0};
    instr_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ld_en   = (k == 1 || k == 2);
      ld_addr = 3'd3;
      ld_data = 16'h1234;
      check("b2b_ready", instr_ready, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 3) begin
        cr = alu_ref(3'd0, rf_m[7], rf_m[3], 4'd0);
        check("b2b_wb_valid", wb_valid, 1);
        check("b2b_wb_data", wb_data, cr[15:0]);
        rf_m[7] = cr[15:0];
        carry_m = cr[16];
        zero_m  = (cr[15:0] == 16'h0);
      end else begin
        check("b2b_no_wb", wb_valid, 0);
      end
      if (k % 4 == 0) begin
        check("b2b_carry", carry_flag, carry_m);
        check("b2b_zero", zero_flag, zero_m);
      end
      if (k == 12) instr_valid = 1'b0;
    end
    ld_en = 1'b0;
    read_reg(3'd3);
    read_reg(3'd7);

    // Randomized instructions with occasional preloads
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        preload(3'($urandom_range(0, 7)), 16'($urandom));
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    for (int r = 0; r < 8; r++) read_reg(3'(r));

    n = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
